// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the host-side program loader: FSM state encoding,
// abort codes, and the instruction-memory geometry defaults that the
// instruction memory also uses.
// -----------------------------------------------------------------------------
package loader_pkg;

   localparam int unsigned IMEM_DEPTH = 1024;
   localparam int unsigned INSTR_W    = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ARM   = 3'd2,
      ST_START = 3'd3,
      ST_RUN   = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } loader_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_OVF     = 2'b01,
      ERR_TIMEOUT = 2'b10
   } loader_err_t;

   // The CPU is released only while starting, running, or parked in DONE so
   // that its final state stays observable.
   function automatic logic cpu_reset_for(input loader_state_t s);
      return !((s == ST_START) || (s == ST_RUN) || (s == ST_DONE));
   endfunction

   function automatic logic busy_for(input loader_state_t s);
      return (s == ST_LOAD) || (s == ST_ARM) || (s == ST_START) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/run_timer.sv
// -----------------------------------------------------------------------------
// run_timer
// 32-bit run-cycle counter with synchronous clear and count enable.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   clear_i          : zero the count (takes priority over enable)
//   enable_i         : count one cycle
//   count_o          : current count
//   timeout_o        : high when the next enabled cycle brings the count to LIMIT
// -----------------------------------------------------------------------------
module run_timer #(
   parameter logic [31:0] LIMIT = 32'd1_000_000
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        clear_i,
   input  logic        enable_i,
   output logic [31:0] count_o,
   output logic        timeout_o
);

   logic [31:0] count_q;

   // Cycle counter; the saturation guard only matters if LIMIT were 2^32-1.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         count_q <= 32'd0;
      end else if (clear_i) begin
         count_q <= 32'd0;
      end else if (enable_i && (count_q != 32'hFFFF_FFFF)) begin
         count_q <= count_q + 32'd1;
      end else begin
         count_q <= count_q;
      end
   end

   // Flagged one cycle early so the FSM leaves RUN on the edge that makes
   // the count equal LIMIT.
   assign timeout_o = (count_q >= (LIMIT - 32'd1));
   assign count_o   = count_q;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Streams instructions from the host into instruction memory, then holds the
// CPU in reset, pulses start and times the run until done or timeout.
//   load_req_i                       : begin a load (IDLE/DONE/ERR only)
//   in_valid_i/in_ready_o/in_data_i/in_last_i : host word stream
//   imem_we_o/imem_addr_o/imem_wdata_o: registered memory write port
//   cpu_reset_o/cpu_start_o/cpu_done_i: CPU run control
//   busy_o/run_done_o/error_o/err_code_o : status levels
//   words_loaded_o, cycle_count_o    : last load size and last run length
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int unsigned IMEM_DEPTH = loader_pkg::IMEM_DEPTH,
   parameter int unsigned INSTR_W    = loader_pkg::INSTR_W,
   parameter logic [31:0] TIMEOUT    = 32'd1_000_000
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          load_req_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [INSTR_W-1:0]            in_data_i,
   input  logic                          in_last_i,
   output logic                          imem_we_o,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr_o,
   output logic [INSTR_W-1:0]            imem_wdata_o,
   output logic                          cpu_reset_o,
   output logic                          cpu_start_o,
   input  logic                          cpu_done_i,
   output logic                          busy_o,
   output logic                          run_done_o,
   output logic                          error_o,
   output logic [1:0]                    err_code_o,
   output logic [$clog2(IMEM_DEPTH):0]   words_loaded_o,
   output logic [31:0]                   cycle_count_o
);

   import loader_pkg::*;

   localparam int unsigned AW      = $clog2(IMEM_DEPTH);
   localparam logic [AW:0] FULL_W  = (AW+1)'(IMEM_DEPTH);
   localparam logic [AW:0] LAST_W  = (AW+1)'(IMEM_DEPTH - 1);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   loader_state_t      state_q, state_d;
   loader_err_t        err_q;
   logic               arm_cnt_q;
   logic [AW:0]        words_q;
   logic               we_q;
   logic [AW-1:0]      addr_q;
   logic [INSTR_W-1:0] wdata_q;
   logic               in_ready_q, cpu_reset_q, cpu_start_q;
   logic               busy_q, run_done_q, error_q;

   logic               hs_s, load_go_s, tmr_en_s, tmr_timeout_s;
   logic [31:0]        tmr_count_s;

   // in_ready_q is high exactly in LOAD, so a handshake implies LOAD.
   assign hs_s      = in_valid_i && in_ready_q;
   assign load_go_s = load_req_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                     (state_q == ST_ERR));
   assign tmr_en_s  = (state_q == ST_RUN);

   run_timer #(.LIMIT(TIMEOUT)) u_run_timer (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (load_go_s),
      .enable_i  (tmr_en_s),
      .count_o   (tmr_count_s),
      .timeout_o (tmr_timeout_s)
   );

   // Next-state decode; done beats timeout in RUN, last beats overflow in LOAD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (load_go_s) state_d = ST_LOAD;
            else           state_d = state_q;
         end
         ST_LOAD: begin
            if (hs_s && in_last_i)                    state_d = ST_ARM;
            else if (hs_s && (words_q == LAST_W))     state_d = ST_ERR;
            else                                      state_d = ST_LOAD;
         end
         ST_ARM: begin
            if (arm_cnt_q) state_d = ST_START;
            else           state_d = ST_ARM;
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            if (cpu_done_i)         state_d = ST_DONE;
            else if (tmr_timeout_s) state_d = ST_ERR;
            else                    state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, write register, word counter and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         err_q       <= ERR_NONE;
         arm_cnt_q   <= 1'b0;
         words_q     <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         in_ready_q  <= 1'b0;
         cpu_reset_q <= 1'b1;
         cpu_start_q <= 1'b0;
         busy_q      <= 1'b0;
         run_done_q  <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         // Two ARM cycles: the counter toggles once, then START is taken.
         arm_cnt_q <= (state_q == ST_ARM) ? ~arm_cnt_q : 1'b0;

         we_q <= hs_s;
         if (hs_s) begin
            addr_q  <= words_q[AW-1:0];
            wdata_q <= in_data_i;
         end else begin
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
         end

         if (load_go_s)                     words_q <= '0;
         else if (hs_s && words_q != FULL_W) words_q <= words_q + ONE_W;
         else                               words_q <= words_q;

         if (load_go_s)                                       err_q <= ERR_NONE;
         else if ((state_q == ST_LOAD) && (state_d == ST_ERR)) err_q <= ERR_OVF;
         else if ((state_q == ST_RUN) && (state_d == ST_ERR))  err_q <= ERR_TIMEOUT;
         else                                                 err_q <= err_q;

         in_ready_q  <= (state_d == ST_LOAD);
         cpu_reset_q <= cpu_reset_for(state_d);
         cpu_start_q <= (state_d == ST_START);
         busy_q      <= busy_for(state_d);
         run_done_q  <= (state_d == ST_DONE);
         error_q     <= (state_d == ST_ERR);
      end
   end

   assign in_ready_o     = in_ready_q;
   assign imem_we_o      = we_q;
   assign imem_addr_o    = addr_q;
   assign imem_wdata_o   = wdata_q;
   assign cpu_reset_o    = cpu_reset_q;
   assign cpu_start_o    = cpu_start_q;
   assign busy_o         = busy_q;
   assign run_done_o     = run_done_q;
   assign error_o        = error_q;
   assign err_code_o     = err_q;
   assign words_loaded_o = words_q;
   assign cycle_count_o  = tmr_count_s;

endmodule

// File: doc/program_loader.md
# program_loader

Host-side loader and run controller for the pipelined CPU. It accepts a stream of 9-bit instructions over a valid/ready handshake and writes them into instruction memory through that memory's write port. It then holds the CPU in reset, pulses `start`, and waits for `done`, counting run cycles. It is the writer and initiator counterpart to the CPU's instruction fetch and its start/done handshake.

## Interface
Parameters:
- `IMEM_DEPTH`, 1024 — instruction memory words; address width is `$clog2(IMEM_DEPTH)` = 10.
- `INSTR_W`, 9 — instruction width.
- `TIMEOUT`, 32'd1_000_000 — run-cycle limit before abort.

Ports:
- `clk` in 1 — single clock; all logic on posedge.
- `reset_n` in 1 — synchronous, active-low reset.
- `load_req` in 1 — one-cycle pulse; begins a load. Honoured in IDLE, DONE and ERR only.
- `in_valid` in 1 — host word valid.
- `in_ready` out 1 — loader accepts a word.
- `in_data` in `INSTR_W` — instruction word.
- `in_last` in 1 — marks the final word of the program.
- `imem_we` out 1 — instruction memory write enable.
- `imem_addr` out 10 — write address.
- `imem_wdata` out `INSTR_W` — write data.
- `cpu_reset` out 1 — active-high reset to the CPU.
- `cpu_start` out 1 — start pulse to the CPU.
- `cpu_done` in 1 — CPU halt indication; level.
- `busy` out 1 — high in any state except IDLE, DONE and ERR.
- `run_done` out 1 — run completed normally.
- `error` out 1 — run aborted.
- `err_code` out 2 — 01 = overflow, 10 = timeout; 00 otherwise.
- `words_loaded` out 11 — count of words accepted in the last load.
- `cycle_count` out 32 — RUN cycles of the last run.

## Operation
- The FSM has seven states: IDLE, LOAD, ARM, START, RUN, DONE, ERR.
- **IDLE**
  - `cpu_reset`=1, `in_ready`=0.
  - `load_req` → LOAD, clearing `words_loaded`, `cycle_count` and `err_code`.
- **LOAD**
  - `in_ready`=1 and `cpu_reset`=1.
  - On each `in_valid && in_ready`, capture `in_data` into a register and write it at address `words_loaded`, then increment `words_loaded`.
  - Accepted word with `in_last`=1 → ARM.
  - Accepted word 1024 with `in_last`=0 → ERR with `err_code`=01; that word is still written at address 1023.
  - `in_valid` low stalls LOAD indefinitely. There is no load timeout.
- **ARM**
  - `cpu_reset`=1 for exactly 2 cycles, covering the registered final write and flushing the CPU pipeline.
  - Then → START.
- **START**
  - One cycle with `cpu_start`=1 and `cpu_reset`=0, then → RUN.
- **RUN**
  - `cpu_reset`=0.
  - `cycle_count` increments every RUN cycle.
  - `cpu_done` is sampled only in RUN, never in START, because a stale done from the previous program may still be visible there.
  - `cpu_done`=1 → DONE. That cycle is counted.
  - `cycle_count` reaching `TIMEOUT` without done → ERR with `err_code`=10.
- **DONE**
  - `run_done`=1 and `cpu_reset`=0, so CPU state stays observable.
  - Held until `load_req`.
- **ERR**
  - `error`=1 and `cpu_reset`=1.
  - Held until `load_req`.
- **Simultaneous events**
  - `load_req` in LOAD, ARM, START or RUN is ignored.
  - `cpu_done` and timeout in the same cycle → DONE; done wins.
- **Width rules**
  - `words_loaded` saturates at 1024.
  - `cycle_count` cannot wrap, because `TIMEOUT` < 2^32.

## Timing
- **Reset values** (`reset_n` low at a posedge)
  - state=IDLE, `cpu_reset`=1.
  - All other outputs 0, including `words_loaded` and `cycle_count`.
- **Reset mid-operation**
  - Reset in any state applies immediately at that edge.
  - A partially loaded memory is left as-is; no clear.
- **Memory write latency**
  - Handshake at edge N produces `imem_we`/`imem_addr`/`imem_wdata` valid during cycle N+1 for exactly one cycle.
  - Back-to-back handshakes give back-to-back writes.
- **Load to run latency**
  - Final handshake at edge N.
  - ARM during cycles N+1 and N+2.
  - `cpu_start` high during cycle N+3.
  - RUN from cycle N+4.
- **Status strobes**: `run_done` and `error` are levels, not pulses.

## Structure
- `loader_pkg` holds:
  - the `loader_state_t` enum (7 states);
  - the `loader_err_t` codes (ERR_NONE, ERR_OVF, ERR_TIMEOUT);
  - the `IMEM_DEPTH` and `INSTR_W` defaults, shared with instruction memory.
- One sub-module, `run_timer`:
  - 32-bit counter with clear, enable and a `timeout` compare output;
  - instantiated once for RUN.
- The FSM, address counter and write register live in `program_loader`.

## Test plan
- **Normal run**: load 5 words with `in_last` on word 5 → writes to addresses 0..4 with the matching data, `words_loaded`=5. `cpu_start` pulses exactly 3 cycles after the last handshake. `cpu_done` raised 20 cycles into RUN → `run_done`=1, `cycle_count`=20.
- **Backpressure gaps**: `in_valid` toggling 1/0 each cycle across 4 words → exactly 4 writes, addresses 0..3, no duplicates.
- **Overflow**: 1024 words, none marked last → last write at address 1023, then `error`=1, `err_code`=01, `cpu_reset`=1, `cpu_start` never asserted.
- **Timeout**: `TIMEOUT`=100 with `cpu_done` held low → ERR with `err_code`=10 after 100 RUN cycles and `cycle_count`=100. A subsequent `load_req` → LOAD with `err_code`=00.
- **Stale done**: `cpu_done` held high through ARM and START, dropped in the first RUN cycle, then raised 10 cycles later → DONE with `cycle_count`=11, not 1.
- **Reset mid-RUN**: `reset_n` low for 1 cycle → next cycle IDLE, `cpu_reset`=1, counters 0, `busy`=0. `load_req` during RUN without reset → ignored.
